// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter: the queued MDU result
// record and the register-file geometry.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int NREGS = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                 fp;
        logic [4:0]           rd;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    // One-hot decode of a destination register, used to build the busy vectors.
    function automatic logic [NREGS-1:0] rd_onehot(input logic [4:0] rd);
        logic [NREGS-1:0] vec;
        vec = '0;
        vec[rd] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of execute-side results, register-file write ports and busy vectors
// seen by the writeback arbiter.
interface wb_arbiter_if #(
    parameter int DATA_W = 32
) ();
    import wb_pkg::*;

    logic              alu_valid;
    logic              alu_fp;
    logic [4:0]        alu_rd;
    logic [DATA_W-1:0] alu_data;

    logic              mdu_valid;
    logic              mdu_ready;
    logic              mdu_fp;
    logic [4:0]        mdu_rd;
    logic [DATA_W-1:0] mdu_data;

    logic              int_reg_write;
    logic [4:0]        int_rd;
    logic [DATA_W-1:0] int_write_data;

    logic              fp_reg_write;
    logic [4:0]        fp_rd;
    logic [DATA_W-1:0] fp_write_data;

    logic [NREGS-1:0]  busy_int;
    logic [NREGS-1:0]  busy_fp;

    // The arbiter side.
    modport slave (
        input  alu_valid, alu_fp, alu_rd, alu_data,
        input  mdu_valid, mdu_fp, mdu_rd, mdu_data,
        output mdu_ready,
        output int_reg_write, int_rd, int_write_data,
        output fp_reg_write, fp_rd, fp_write_data,
        output busy_int, busy_fp
    );

    // The execute stages / register files side.
    modport master (
        output alu_valid, alu_fp, alu_rd, alu_data,
        output mdu_valid, mdu_fp, mdu_rd, mdu_data,
        input  mdu_ready,
        input  int_reg_write, int_rd, int_write_data,
        input  fp_reg_write, fp_rd, fp_write_data,
        input  busy_int, busy_fp
    );

endinterface

// File: rtl/wb_fifo.sv
// Small in-order FIFO for queued MDU results; exposes its storage and per-entry
// valid bits so the parent can see every pending destination at once.
module wb_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  T              data_i,
    output T              head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output T              entries_o [DEPTH],
    output logic [DEPTH-1:0] valid_o
);

    T              mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pushEn;
    logic          popEn;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rdPtr_q];
    assign entries_o = mem_q;

    assign pushEn = push_i && !full_o;
    assign popEn  = pop_i && !empty_o;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushEn) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (popEn) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        case ({pushEn, popEn})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Entry i is live when its distance from the read pointer is below the count.
    always_comb begin
        logic [PW-1:0] offs;
        offs = '0;
        valid_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - rdPtr_q;
            valid_o[i] = (CW'(offs) < count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (pushEn) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Merges single-cycle ALU results and queued MDU results onto the integer and
// float register-file write ports, with pending-write busy vectors for issue.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_req_t          mduReq;
    wb_req_t          headReq;
    wb_req_t          entries [DEPTH];
    logic [DEPTH-1:0] entryValid;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [CW-1:0]    fifoCount;
    logic             mduReady;
    logic             push;
    logic             pop;

    logic             aluInt, aluFp;
    logic             headInt, headFp;

    logic              intWrite_q, intWrite_d;
    logic [4:0]        intRd_q, intRd_d;
    logic [DATA_W-1:0] intData_q, intData_d;
    logic              fpWrite_q, fpWrite_d;
    logic [4:0]        fpRd_q, fpRd_d;
    logic [DATA_W-1:0] fpData_q, fpData_d;

    logic [NREGS-1:0]  busyInt;
    logic [NREGS-1:0]  busyFp;

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
    assign mduReady = rst_n && (fifoCount < CW'(DEPTH));
    assign push     = bus.mdu_valid && mduReady && !fifoFull;

    assign mduReq = '{fp: bus.mdu_fp, rd: bus.mdu_rd, data: bus.mdu_data};

    wb_fifo #(
        .DEPTH (DEPTH),
        .T     (wb_req_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .pop_i     (pop),
        .data_i    (mduReq),
        .head_o    (headReq),
        .full_o    (fifoFull),
        .empty_o   (fifoEmpty),
        .count_o   (fifoCount),
        .entries_o (entries),
        .valid_o   (entryValid)
    );

    assign aluInt  = bus.alu_valid && !bus.alu_fp;
    assign aluFp   = bus.alu_valid && bus.alu_fp;
    assign headInt = !fifoEmpty && !headReq.fp;
    assign headFp  = !fifoEmpty && headReq.fp;

    // Each port independently prefers the ALU; the head drains through whichever port it targets if free.
    always_comb begin
        intWrite_d = 1'b0;
        intRd_d    = intRd_q;
        intData_d  = intData_q;
        fpWrite_d  = 1'b0;
        fpRd_d     = fpRd_q;
        fpData_d   = fpData_q;
        pop        = 1'b0;

        if (aluInt) begin
            intWrite_d = (bus.alu_rd != REG_ZERO);
            intRd_d    = bus.alu_rd;
            intData_d  = bus.alu_data;
        end else if (headInt) begin
            intWrite_d = (headReq.rd != REG_ZERO);
            intRd_d    = headReq.rd;
            intData_d  = headReq.data;
            pop        = 1'b1;
        end

        if (aluFp) begin
            fpWrite_d = 1'b1;
            fpRd_d    = bus.alu_rd;
            fpData_d  = bus.alu_data;
        end else if (headFp) begin
            fpWrite_d = 1'b1;
            fpRd_d    = headReq.rd;
            fpData_d  = headReq.data;
            pop       = 1'b1;
        end
    end

    // Integer x0 is never really written, so it is never reported busy either.
    always_comb begin
        busyInt = '0;
        busyFp  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i]) begin
                if (entries[i].fp) begin
                    busyFp = busyFp | rd_onehot(entries[i].rd);
                end else if (entries[i].rd != REG_ZERO) begin
                    busyInt = busyInt | rd_onehot(entries[i].rd);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intWrite_q <= 1'b0;
            intRd_q    <= '0;
            intData_q  <= '0;
            fpWrite_q  <= 1'b0;
            fpRd_q     <= '0;
            fpData_q   <= '0;
        end else begin
            intWrite_q <= intWrite_d;
            intRd_q    <= intRd_d;
            intData_q  <= intData_d;
            fpWrite_q  <= fpWrite_d;
            fpRd_q     <= fpRd_d;
            fpData_q   <= fpData_d;
        end
    end

    assign bus.mdu_ready      = mduReady;
    assign bus.int_reg_write  = intWrite_q;
    assign bus.int_rd         = intRd_q;
    assign bus.int_write_data = intData_q;
    assign bus.fp_reg_write   = fpWrite_q;
    assign bus.fp_rd          = fpRd_q;
    assign bus.fp_write_data  = fpData_q;
    assign bus.busy_int       = busyInt;
    assign bus.busy_fp        = busyFp;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes (register, data, cycle) are
// queued per port and a negedge monitor matches every write the DUT makes.
module tb_wb_arbiter;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   c;
    int   k;
    logic [6:0] readyPat = 7'b1100011;

    exp_t intQ[$];
    exp_t fpQ[$];

    wb_arbiter_if #(.DATA_W(32)) bus ();

    wb_arbiter #(
        .DEPTH  (2),
        .DATA_W (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic aV, input logic aFp, input logic [4:0] aRd,
                                 input logic [31:0] aD, input logic mV, input logic mFp,
                                 input logic [4:0] mRd, input logic [31:0] mD);
        bus.alu_valid = aV;
        bus.alu_fp    = aFp;
        bus.alu_rd    = aRd;
        bus.alu_data  = aD;
        bus.mdu_valid = mV;
        bus.mdu_fp    = mFp;
        bus.mdu_rd    = mRd;
        bus.mdu_data  = mD;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        repeat (n) nextCycle();
    endtask

    task automatic expInt(input logic [4:0] rd, input logic [31:0] data, input int when);
        exp_t e;
        e.rd = rd; e.data = data; e.cyc = when;
        intQ.push_back(e);
    endtask

    task automatic expFp(input logic [4:0] rd, input logic [31:0] data, input int when);
        exp_t e;
        e.rd = rd; e.data = data; e.cyc = when;
        fpQ.push_back(e);
    endtask

    task automatic drainWait();
        int i;
        i = 0;
        while ((intQ.size() + fpQ.size()) != 0 && i < 30) begin
            nextCycle();
            i++;
        end
        checkOutput("pending expected writes", 64'(intQ.size() + fpQ.size()), 64'd0);
    endtask

    // Monitor: every write on either port must match the oldest expectation for that port.
    always @(negedge clk) begin
        exp_t e;
        if (bus.int_reg_write !== 1'b0) begin
            if (intQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected int write: rd=%0d data=0x%0h, required none (cycle %0d)",
                         bus.int_rd, bus.int_write_data, cyc);
            end else begin
                e = intQ.pop_front();
                checkOutput("int_rd", 64'(bus.int_rd), 64'(e.rd));
                checkOutput("int_write_data", 64'(bus.int_write_data), 64'(e.data));
                checkOutput("int write cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (bus.fp_reg_write !== 1'b0) begin
            if (fpQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected fp write: rd=%0d data=0x%0h, required none (cycle %0d)",
                         bus.fp_rd, bus.fp_write_data, cyc);
            end else begin
                e = fpQ.pop_front();
                checkOutput("fp_rd", 64'(bus.fp_rd), 64'(e.rd));
                checkOutput("fp_write_data", 64'(bus.fp_write_data), 64'(e.data));
                checkOutput("fp write cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL global timeout reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset int_reg_write", 64'(bus.int_reg_write), 64'd0);
        checkOutput("reset fp_reg_write", 64'(bus.fp_reg_write), 64'd0);
        checkOutput("reset mdu_ready", 64'(bus.mdu_ready), 64'd0);
        checkOutput("reset busy_int", 64'(bus.busy_int), 64'd0);
        checkOutput("reset busy_fp", 64'(bus.busy_fp), 64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("mdu_ready after release", 64'(bus.mdu_ready), 64'd1);
        idle(1);

        // ALU only
        c = cyc;
        applyStimulus(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'd0);
        expInt(5'd5, 32'hDEADBEEF, c + 1);
        nextCycle();
        idle(2);
        drainWait();

        // ALU blocks the integer port for three cycles while an MDU result waits
        c = cyc;
        checkOutput("ready before conflict", 64'(bus.mdu_ready), 64'd1);
        applyStimulus(1'b1, 1'b0, 5'd3, 32'h11, 1'b1, 1'b0, 5'd4, 32'h22);
        expInt(5'd3, 32'h11, c + 1);
        expInt(5'd3, 32'h11, c + 2);
        expInt(5'd3, 32'h11, c + 3);
        expInt(5'd4, 32'h22, c + 4);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 5'd3, 32'h11, 1'b0, 1'b0, 5'd0, 32'd0);
        checkOutput("conflict busy_int queued", 64'(bus.busy_int), 64'(32'h1 << 4));
        nextCycle();
        nextCycle();
        idle(0);
        checkOutput("conflict busy_int still blocked", 64'(bus.busy_int), 64'(32'h1 << 4));
        nextCycle();
        checkOutput("conflict busy_int after pop", 64'(bus.busy_int), 64'd0);
        drainWait();

        // Queued float result drains alongside an integer ALU write
        c = cyc;
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd2, 32'h33);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 5'd1, 32'h44, 1'b0, 1'b0, 5'd0, 32'd0);
        expInt(5'd1, 32'h44, c + 2);
        expFp(5'd2, 32'h33, c + 2);
        nextCycle();
        idle(2);
        drainWait();

        // Back-pressure: ALU holds the float port for 4 cycles, MDU offers 3 float results
        c = cyc;
        k = 0;
        for (int i = 0; i < 4; i++) expFp(5'd10, 32'(32'hA0 + i), c + 1 + i);
        expFp(5'd20, 32'hB0, c + 5);
        expFp(5'd21, 32'hB1, c + 6);
        expFp(5'd22, 32'hB2, c + 7);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(i < 4, 1'b1, 5'd10, 32'(32'hA0 + i),
                          k < 3, 1'b1, 5'(20 + k), 32'(32'hB0 + k));
            checkOutput($sformatf("mdu_ready full step %0d", i), 64'(bus.mdu_ready), 64'(readyPat[i]));
            if (i == 2) begin
                checkOutput("full busy_fp", 64'(bus.busy_fp), 64'((32'h1 << 20) | (32'h1 << 21)));
            end
            if (k < 3 && bus.mdu_ready === 1'b1) begin
                nextCycle();
                k++;
            end else begin
                nextCycle();
            end
        end
        idle(1);
        drainWait();

        // Zero register handling
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h99, 1'b0, 1'b0, 5'd0, 32'd0);
        nextCycle();
        idle(2);
        checkOutput("ready before int x0 push", 64'(bus.mdu_ready), 64'd1);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'h77);
        nextCycle();
        idle(0);
        checkOutput("int x0 busy_int", 64'(bus.busy_int), 64'd0);
        checkOutput("int x0 busy_fp", 64'(bus.busy_fp), 64'd0);
        idle(2);
        c = cyc;
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd0, 32'h55);
        expFp(5'd0, 32'h55, c + 2);
        nextCycle();
        idle(2);
        drainWait();

        // Reset while the FIFO holds two entries
        c = cyc;
        applyStimulus(1'b1, 1'b0, 5'd7, 32'h70, 1'b1, 1'b0, 5'd8, 32'h80);
        expInt(5'd7, 32'h70, c + 1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 5'd7, 32'h71, 1'b1, 1'b0, 5'd9, 32'h90);
        expInt(5'd7, 32'h71, c + 2);
        nextCycle();
        idle(0);
        checkOutput("pre-reset busy_int", 64'(bus.busy_int), 64'((32'h1 << 8) | (32'h1 << 9)));
        checkOutput("pre-reset mdu_ready", 64'(bus.mdu_ready), 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset int_reg_write", 64'(bus.int_reg_write), 64'd0);
        checkOutput("mid reset int_rd", 64'(bus.int_rd), 64'd0);
        checkOutput("mid reset int_write_data", 64'(bus.int_write_data), 64'd0);
        checkOutput("mid reset fp_reg_write", 64'(bus.fp_reg_write), 64'd0);
        checkOutput("mid reset busy_int", 64'(bus.busy_int), 64'd0);
        checkOutput("mid reset busy_fp", 64'(bus.busy_fp), 64'd0);
        checkOutput("mid reset mdu_ready", 64'(bus.mdu_ready), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post reset mdu_ready", 64'(bus.mdu_ready), 64'd1);
        idle(4);
        checkOutput("post reset busy_int", 64'(bus.busy_int), 64'd0);
        drainWait();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter sitting between the execute stages and the integer and float register files. It merges single-cycle ALU results with results from the long-latency multiply/divide/FP unit (MDU) into the two register-file write ports (`rd`, `write_data`, `reg_write`). MDU results wait in a small FIFO whenever the ALU owns the target file's port. Pending-write scoreboard vectors let the issue stage stall on registers with queued writes.

## Interface
- `DEPTH`, 2: MDU result FIFO entries (power of two, ≥2).
- `DATA_W`, 32: result width.

- `clk` in 1: clock; all state on posedge.
- `rst_n` in 1: asynchronous active-low reset.
- `alu_valid` in 1: ALU result present this cycle; always accepted, never back-pressured.
- `alu_fp` in 1: target file; 1 = float, 0 = integer.
- `alu_rd` in 5: destination register.
- `alu_data` in DATA_W: result.
- `mdu_valid` in 1: MDU result offered.
- `mdu_ready` out 1: FIFO can accept; equals `count < DEPTH`, and is 0 while `rst_n` = 0.
- `mdu_fp` in 1, `mdu_rd` in 5, `mdu_data` in DATA_W: MDU result fields.
- `int_reg_write` out 1, `int_rd` out 5, `int_write_data` out DATA_W: integer file write port.
- `fp_reg_write` out 1, `fp_rd` out 5, `fp_write_data` out DATA_W: float file write port.
- `busy_int` out 32, `busy_fp` out 32: bit *r* is set while a FIFO entry targets register *r* in that file.

## Operation
- MDU handshake: a transfer occurs when `mdu_valid && mdu_ready` at posedge. The entry is pushed at FIFO tail. `mdu_valid` and its fields stay stable until the transfer.
- Per cycle, for each file independently:
  - If `alu_valid` targets the file, the ALU result drives that port at the next edge.
  - Otherwise, if the FIFO head targets the file, the head drives the port and is popped.
  - Otherwise `reg_write` is 0 at the next edge.
- At most one FIFO pop per cycle; only the head is eligible, so entries complete in order.
- If the ALU targets the integer file while the head targets float, the head still drains that cycle.
- Integer writes with rd = 0 are suppressed:
  - An ALU rd = 0 integer result produces `int_reg_write` = 0.
  - An MDU rd = 0 integer entry is pushed and then popped without asserting `int_reg_write`.
  - It never sets `busy_int[0]`.
- Float rd = 0 is a normal register.
- `busy_*` is the OR over valid FIFO entries of a one-hot decode of rd. It is combinational from FIFO state and includes an entry pushed at the previous edge.
- Ordering between an ALU result and an older queued write to the same register is the issue stage's responsibility, enforced via `busy_*`. The arbiter never drops or reorders a write.
- Push and pop in the same cycle are allowed whenever `mdu_ready` = 1.
- Count arithmetic uses a `$clog2(DEPTH)+1`-bit counter. Pointers are `$clog2(DEPTH)` bits and wrap naturally.

## Timing
- All write-port outputs are registered; latency is 1 cycle.
  - ALU result at edge N: `reg_write` high during cycle N+1.
  - MDU result accepted at edge N into an empty FIFO: pop is evaluated in cycle N+1, so `reg_write` is high in cycle N+2 at the earliest.
- A FIFO head blocked by the ALU waits until the first cycle the ALU does not target its file.
- Reset, asynchronous assert:
  - All `*_reg_write`, `*_rd` and `*_write_data` go to 0.
  - FIFO empties; `busy_*` = 0; `mdu_ready` = 0.
  - In-flight MDU results are discarded.
- After `rst_n` deasserts, `mdu_ready` = 1 the same cycle. The first writes can occur one edge after the first accepted input.
- Full boundary: with count = DEPTH, `mdu_ready` = 0 even if a pop happens that cycle. There is no combinational ready-from-pop path.

## Structure
- `wb_pkg`:
  - `wb_req_t` struct {`fp`, `rd`[4:0], `data`[DATA_W-1:0]}.
  - `REG_ZERO` = 5'd0.
  - `NREGS` = 32.
- Sub-module `wb_fifo`:
  - Parameterized on DEPTH and the element type.
  - Ports: push/pop/full/empty/count, head output.
  - Exposes its entry array and valid bits so `wb_arbiter` can build `busy_*`.
- `wb_arbiter` holds the selection logic, rd = 0 suppression and output registers.

## Test plan
- **ALU only:** `alu_valid`, `fp`=0, `rd`=5, `data`=0xDEADBEEF at edge N → `int_reg_write`=1, `int_rd`=5, `int_write_data`=0xDEADBEEF in cycle N+1; `fp_reg_write`=0.
- **Conflict:** ALU int rd=3, 0x11 held for 3 cycles; MDU int rd=4, 0x22 pushed in the first.
  - `int_reg_write` carries rd=3 for 3 cycles, then rd=4/0x22.
  - `busy_int[4]` = 1 until the pop edge.
- **Cross-file drain:** ALU int rd=1 and MDU float rd=2 (queued) → both ports write in the same cycle.
- **Full/back-pressure:** ALU holds float for 4 cycles while the MDU offers 3 float results.
  - `mdu_ready` = 0 after 2 pushes; the third is accepted the cycle after the first pop.
  - Writes appear in push order.
- **Zero register:**
  - ALU int rd=0 → no `int_reg_write`.
  - MDU int rd=0 → accepted, `busy_int` stays 0, no write.
  - MDU float rd=0 → `fp_reg_write`=1 with `fp_rd`=0.
- **Reset mid-operation:** FIFO holds 2 entries when `rst_n` pulses low → outputs, `busy_*` and `mdu_ready` go 0 immediately; no stale write after release.
